// File: rtl/bp_clint_pkg.sv
// Shared constants, enums and size helpers for the CLINT responder.
package bp_clint_pkg;

  localparam logic [15:0] clint_mipi_offset_gp     = 16'h0000;
  localparam logic [15:0] clint_mtimecmp_offset_gp = 16'h4000;
  localparam logic [15:0] clint_plic_offset_gp     = 16'hB000;
  localparam logic [15:0] clint_mtime_offset_gp    = 16'hBFF8;
  localparam logic [3:0]  clint_dev_gp             = 4'd3;

  typedef enum logic [1:0] {
    SizeB = 2'd0,
    SizeH = 2'd1,
    SizeW = 2'd2,
    SizeD = 2'd3
  } bp_clint_size_e;

  typedef enum logic {
    StReady = 1'b0,
    StResp  = 1'b1
  } bp_clint_state_e;

  function automatic logic [7:0] size_byte_mask(input bp_clint_size_e size);
    logic [7:0] mask;
    unique case (size)
      SizeB:   mask = 8'h01;
      SizeH:   mask = 8'h03;
      SizeW:   mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  function automatic logic is_aligned(input logic [2:0] offset, input bp_clint_size_e size);
    logic ok;
    unique case (size)
      SizeB:   ok = 1'b1;
      SizeH:   ok = (offset[0] == 1'b0);
      SizeW:   ok = (offset[1:0] == 2'b00);
      default: ok = (offset == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/bp_clint_subword.sv
// Sub-word access helper: load extract/zero-extend and store byte-merge for one 64b register.
module bp_clint_subword
  import bp_clint_pkg::*;
(
  input  logic [2:0]     i_offset,
  input  bp_clint_size_e i_size,
  input  logic [63:0]    i_reg,
  input  logic [63:0]    i_wdata,
  output logic [63:0]    o_rdata,
  output logic [63:0]    o_merged
);

  logic [5:0]  w_shamt;
  logic [7:0]  w_size_bytes;
  logic [7:0]  w_byte_mask;
  logic [63:0] w_size_bits;
  logic [63:0] w_bit_mask;

  assign w_shamt      = {i_offset, 3'b000};
  assign w_size_bytes = size_byte_mask(i_size);
  assign w_byte_mask  = w_size_bytes << i_offset;

  always_comb begin
    w_size_bits = '0;
    w_bit_mask  = '0;
    for (int i = 0; i < 8; i++) begin
      w_size_bits[i*8 +: 8] = {8{w_size_bytes[i]}};
      w_bit_mask[i*8 +: 8]  = {8{w_byte_mask[i]}};
    end
  end

  assign o_rdata  = (i_reg >> w_shamt) & w_size_bits;
  assign o_merged = (i_reg & ~w_bit_mask) | ((i_wdata << w_shamt) & w_bit_mask);

endmodule

// File: rtl/bp_clint_responder.sv
// CLINT memory-mapped responder: mipi, mtimecmp, mtime and PLIC pending bit for one hart.
module bp_clint_responder
  import bp_clint_pkg::*;
#(
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     rtc_tick_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic                     req_wr_i,
  input  logic [paddr_width_p-1:0] req_addr_i,
  input  logic [1:0]               req_size_i,
  input  logic [data_width_p-1:0]  req_data_i,
  output logic                     resp_v_o,
  input  logic                     resp_yumi_i,
  output logic                     resp_wr_o,
  output logic                     resp_err_o,
  output logic [data_width_p-1:0]  resp_data_o,
  output logic                     software_irq_o,
  output logic                     timer_irq_o,
  output logic                     external_irq_o
);

  bp_clint_state_e r_state, w_state_next;

  logic        r_mipi;
  logic        r_plic;
  logic [63:0] r_mtimecmp;
  logic [63:0] r_mtime;
  logic        r_timer_irq;
  logic        r_resp_wr;
  logic        r_resp_err;
  logic [63:0] r_resp_data;

  logic [2:0]     w_offset;
  bp_clint_size_e w_size;
  logic [12:0]    w_word;
  logic           w_err;
  logic           w_accept;
  logic           w_wen;
  logic           w_hit_mipi, w_hit_mtimecmp, w_hit_plic, w_hit_mtime;
  logic [63:0]    w_rd_mipi, w_rd_mtimecmp, w_rd_plic, w_rd_mtime;
  logic [63:0]    w_mg_mipi, w_mg_mtimecmp, w_mg_plic, w_mg_mtime;
  logic [63:0]    w_load_data;

  assign w_offset = req_addr_i[2:0];
  assign w_size   = bp_clint_size_e'(req_size_i);
  assign w_word   = req_addr_i[15:3];
  assign w_err    = (req_addr_i[23:20] != clint_dev_gp) || !is_aligned(w_offset, w_size);

  assign w_hit_mipi     = (w_word == clint_mipi_offset_gp[15:3]);
  assign w_hit_mtimecmp = (w_word == clint_mtimecmp_offset_gp[15:3]);
  assign w_hit_plic     = (w_word == clint_plic_offset_gp[15:3]);
  assign w_hit_mtime    = (w_word == clint_mtime_offset_gp[15:3]);

  // Ready is forced low while reset is held so nothing is accepted mid-reset.
  assign req_ready_o = (r_state == StReady) && reset_n_i;
  assign w_accept    = req_ready_o && req_v_i;
  assign w_wen       = w_accept && req_wr_i && !w_err;

  bp_clint_subword u_sw_mipi (
    .i_offset (w_offset),
    .i_size   (w_size),
    .i_reg    ({63'd0, r_mipi}),
    .i_wdata  (req_data_i),
    .o_rdata  (w_rd_mipi),
    .o_merged (w_mg_mipi)
  );

  bp_clint_subword u_sw_mtimecmp (
    .i_offset (w_offset),
    .i_size   (w_size),
    .i_reg    (r_mtimecmp),
    .i_wdata  (req_data_i),
    .o_rdata  (w_rd_mtimecmp),
    .o_merged (w_mg_mtimecmp)
  );

  bp_clint_subword u_sw_plic (
    .i_offset (w_offset),
    .i_size   (w_size),
    .i_reg    ({63'd0, r_plic}),
    .i_wdata  (req_data_i),
    .o_rdata  (w_rd_plic),
    .o_merged (w_mg_plic)
  );

  bp_clint_subword u_sw_mtime (
    .i_offset (w_offset),
    .i_size   (w_size),
    .i_reg    (r_mtime),
    .i_wdata  (req_data_i),
    .o_rdata  (w_rd_mtime),
    .o_merged (w_mg_mtime)
  );

  always_comb begin
    w_load_data = '0;
    if (!w_err && !req_wr_i) begin
      if (w_hit_mipi)          w_load_data = w_rd_mipi;
      else if (w_hit_mtimecmp) w_load_data = w_rd_mtimecmp;
      else if (w_hit_plic)     w_load_data = w_rd_plic;
      else if (w_hit_mtime)    w_load_data = w_rd_mtime;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StReady: if (w_accept) w_state_next = StResp;
      StResp:  if (resp_yumi_i) w_state_next = StReady;
      default: w_state_next = StReady;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= StReady;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_mipi     <= 1'b0;
      r_plic     <= 1'b0;
      r_mtimecmp <= '1;
    end else if (w_wen) begin
      if (w_hit_mipi)     r_mipi     <= w_mg_mipi[0];
      if (w_hit_plic)     r_plic     <= w_mg_plic[0];
      if (w_hit_mtimecmp) r_mtimecmp <= w_mg_mtimecmp;
    end
  end

  // A store to mtime overrides a coincident tick.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_mtime <= '0;
    end else if (w_wen && w_hit_mtime) begin
      r_mtime <= w_mg_mtime;
    end else if (rtc_tick_i) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_timer_irq <= 1'b0;
    end else begin
      r_timer_irq <= (r_mtime >= r_mtimecmp);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_resp_wr   <= 1'b0;
      r_resp_err  <= 1'b0;
      r_resp_data <= '0;
    end else if (w_accept) begin
      r_resp_wr   <= req_wr_i;
      r_resp_err  <= w_err;
      r_resp_data <= w_load_data;
    end
  end

  assign resp_v_o       = (r_state == StResp);
  assign resp_wr_o      = r_resp_wr;
  assign resp_err_o     = r_resp_err;
  assign resp_data_o    = r_resp_data;
  assign software_irq_o = r_mipi;
  assign timer_irq_o    = r_timer_irq;
  assign external_irq_o = r_plic;

  logic w_unused;
  assign w_unused = ^{req_addr_i[paddr_width_p-1:24], req_addr_i[19:16],
                      w_mg_mipi[63:1], w_mg_plic[63:1]};

endmodule

// File: tb/tb_bp_clint_responder.sv
// Directed self-checking bench for bp_clint_responder.
module tb_bp_clint_responder;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        rtc_tick_i;
  logic        req_v_i;
  logic        req_ready_o;
  logic        req_wr_i;
  logic [39:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic [63:0] req_data_i;
  logic        resp_v_o;
  logic        resp_yumi_i;
  logic        resp_wr_o;
  logic        resp_err_o;
  logic [63:0] resp_data_o;
  logic        software_irq_o;
  logic        timer_irq_o;
  logic        external_irq_o;

  int n_pass  = 0;
  int n_total = 0;

  bp_clint_responder #(
    .paddr_width_p (40),
    .data_width_p  (64)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .rtc_tick_i     (rtc_tick_i),
    .req_v_i        (req_v_i),
    .req_ready_o    (req_ready_o),
    .req_wr_i       (req_wr_i),
    .req_addr_i     (req_addr_i),
    .req_size_i     (req_size_i),
    .req_data_i     (req_data_i),
    .resp_v_o       (resp_v_o),
    .resp_yumi_i    (resp_yumi_i),
    .resp_wr_o      (resp_wr_o),
    .resp_err_o     (resp_err_o),
    .resp_data_o    (resp_data_o),
    .software_irq_o (software_irq_o),
    .timer_irq_o    (timer_irq_o),
    .external_irq_o (external_irq_o)
  );

  always #5 clk_i = ~clk_i;

  // One full transaction; inputs change and outputs are sampled on negedges.
  task automatic txn(input logic wr, input logic [39:0] addr, input logic [1:0] size,
                     input logic [63:0] data, input logic tick,
                     output logic [63:0] rdata, output logic err, output logic rwr);
    int n;
    @(negedge clk_i);
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      n_total++;
      $display("FAIL txn_ready_timeout addr=%h got ready=%b want 1", addr, req_ready_o);
    end
    req_v_i    = 1'b1;
    req_wr_i   = wr;
    req_addr_i = addr;
    req_size_i = size;
    req_data_i = data;
    rtc_tick_i = tick;
    @(negedge clk_i);
    req_v_i    = 1'b0;
    rtc_tick_i = 1'b0;
    n = 0;
    while (!resp_v_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!resp_v_o) begin
      n_total++;
      $display("FAIL txn_resp_timeout addr=%h got resp_v=%b want 1", addr, resp_v_o);
    end
    rdata = resp_data_o;
    err   = resp_err_o;
    rwr   = resp_wr_o;
    resp_yumi_i = 1'b1;
    @(negedge clk_i);
    resp_yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    logic e, w;
    reset_n_i = 1'b0;
    #23;
    n_total++;
    if ({req_ready_o, resp_v_o, resp_err_o, resp_wr_o} !== 4'b0000 || resp_data_o !== 64'd0) begin
      $display("FAIL reset_outputs got rdy/v/err/wr=%b%b%b%b data=%h want 0000 0",
               req_ready_o, resp_v_o, resp_err_o, resp_wr_o, resp_data_o);
    end else n_pass++;
    n_total++;
    if ({software_irq_o, timer_irq_o, external_irq_o} !== 3'b000) begin
      $display("FAIL reset_irqs got %b%b%b want 000", software_irq_o, timer_irq_o, external_irq_o);
    end else n_pass++;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    txn(1'b0, 40'h00_0030_4000, 2'd3, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF || e !== 1'b0) begin
      $display("FAIL reset_mtimecmp got data=%h err=%b want ffffffffffffffff 0", d, e);
    end else n_pass++;
    n_total++;
    if (timer_irq_o !== 1'b0) begin
      $display("FAIL reset_timer_irq got %b want 0", timer_irq_o);
    end else n_pass++;
  endtask

  task automatic test_mipi_plic();
    logic [63:0] d;
    logic e, w;
    txn(1'b1, 40'h00_0030_0000, 2'd3, 64'd1, 1'b0, d, e, w);
    n_total++;
    if (software_irq_o !== 1'b1) begin
      $display("FAIL mipi_set got sw_irq=%b want 1", software_irq_o);
    end else n_pass++;
    n_total++;
    if (w !== 1'b1 || d !== 64'd0 || e !== 1'b0) begin
      $display("FAIL store_resp got wr=%b data=%h err=%b want 1 0 0", w, d, e);
    end else n_pass++;
    txn(1'b1, 40'h00_0030_0000, 2'd0, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (software_irq_o !== 1'b0) begin
      $display("FAIL mipi_clear got sw_irq=%b want 0", software_irq_o);
    end else n_pass++;
    txn(1'b1, 40'h00_0030_0000, 2'd3, 64'hFFFF, 1'b0, d, e, w);
    txn(1'b0, 40'h00_0030_0000, 2'd3, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (d !== 64'd1 || w !== 1'b0) begin
      $display("FAIL mipi_load got data=%h wr=%b want 1 0", d, w);
    end else n_pass++;
    txn(1'b1, 40'h00_0030_B000, 2'd3, 64'd3, 1'b0, d, e, w);
    txn(1'b0, 40'h00_0030_B000, 2'd3, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (external_irq_o !== 1'b1 || d !== 64'd1) begin
      $display("FAIL plic_set got ext_irq=%b data=%h want 1 1", external_irq_o, d);
    end else n_pass++;
  endtask

  task automatic test_timer();
    logic [63:0] d;
    logic e, w;
    txn(1'b1, 40'h00_0030_4000, 2'd3, 64'd5, 1'b0, d, e, w);
    txn(1'b1, 40'h00_0030_BFF8, 2'd3, 64'd0, 1'b0, d, e, w);
    for (int i = 0; i < 5; i++) begin
      rtc_tick_i = 1'b1;
      @(negedge clk_i);
    end
    rtc_tick_i = 1'b0;
    n_total++;
    if (timer_irq_o !== 1'b0) begin
      $display("FAIL timer_irq_early got %b want 0", timer_irq_o);
    end else n_pass++;
    @(negedge clk_i);
    n_total++;
    if (timer_irq_o !== 1'b1) begin
      $display("FAIL timer_irq_rise got %b want 1", timer_irq_o);
    end else n_pass++;
    txn(1'b1, 40'h00_0030_4004, 2'd2, 64'd1, 1'b0, d, e, w);
    n_total++;
    if (timer_irq_o !== 1'b0) begin
      $display("FAIL timer_irq_fall got %b want 0", timer_irq_o);
    end else n_pass++;
    txn(1'b0, 40'h00_0030_4000, 2'd3, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (d !== 64'h1_0000_0005) begin
      $display("FAIL mtimecmp_upper got %h want 0000000100000005", d);
    end else n_pass++;
  endtask

  task automatic test_mtime_subword();
    logic [63:0] d;
    logic e, w;
    txn(1'b1, 40'h00_0030_BFFA, 2'd1, 64'hABCD, 1'b0, d, e, w);
    txn(1'b0, 40'h00_0030_BFF8, 2'd3, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (d !== 64'h0000_0000_ABCD_0005) begin
      $display("FAIL mtime_half_store got %h want 00000000abcd0005", d);
    end else n_pass++;
    txn(1'b0, 40'h00_0030_BFFB, 2'd0, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (d !== 64'hAB || e !== 1'b0) begin
      $display("FAIL mtime_byte_load got data=%h err=%b want ab 0", d, e);
    end else n_pass++;
  endtask

  task automatic test_mtime_tick_collision();
    logic [63:0] d;
    logic e, w;
    txn(1'b1, 40'h00_0030_BFF8, 2'd3, 64'd100, 1'b1, d, e, w);
    txn(1'b0, 40'h00_0030_BFF8, 2'd3, 64'd0, 1'b1, d, e, w);
    n_total++;
    if (d !== 64'd100) begin
      $display("FAIL store_beats_tick got %0d want 100", d);
    end else n_pass++;
    txn(1'b0, 40'h00_0030_BFF8, 2'd3, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (d !== 64'd101) begin
      $display("FAIL tick_after_load got %0d want 101", d);
    end else n_pass++;
    txn(1'b1, 40'h00_0030_BFF8, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, d, e, w);
    txn(1'b0, 40'h00_0030_BFF8, 2'd3, 64'd0, 1'b1, d, e, w);
    txn(1'b0, 40'h00_0030_BFF8, 2'd3, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (d !== 64'd0) begin
      $display("FAIL mtime_wrap got %h want 0", d);
    end else n_pass++;
  endtask

  task automatic test_errors();
    logic [63:0] d;
    logic e, w;
    txn(1'b0, 40'h00_0030_0002, 2'd2, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (e !== 1'b1 || d !== 64'd0) begin
      $display("FAIL misaligned_load got err=%b data=%h want 1 0", e, d);
    end else n_pass++;
    txn(1'b1, 40'h00_0030_BFFA, 2'd2, 64'hFFFF_FFFF, 1'b0, d, e, w);
    n_total++;
    if (e !== 1'b1 || w !== 1'b1) begin
      $display("FAIL misaligned_store got err=%b wr=%b want 1 1", e, w);
    end else n_pass++;
    txn(1'b0, 40'h00_0030_BFF8, 2'd3, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (d !== 64'd0) begin
      $display("FAIL misaligned_no_effect got mtime=%h want 0", d);
    end else n_pass++;
    txn(1'b0, 40'h00_0020_0000, 2'd3, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (e !== 1'b1 || d !== 64'd0) begin
      $display("FAIL bad_device got err=%b data=%h want 1 0", e, d);
    end else n_pass++;
    txn(1'b0, 40'h00_0020_4000, 2'd3, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (e !== 1'b1 || d !== 64'd0) begin
      $display("FAIL bad_device_valid_offset got err=%b data=%h want 1 0", e, d);
    end else n_pass++;
    txn(1'b0, 40'h00_0030_1000, 2'd3, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (e !== 1'b0 || d !== 64'd0) begin
      $display("FAIL unmapped_offset got err=%b data=%h want 0 0", e, d);
    end else n_pass++;
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk_i);
    req_v_i    = 1'b1;
    req_wr_i   = 1'b0;
    req_addr_i = 40'h00_0030_4000;
    req_size_i = 2'd3;
    @(negedge clk_i);
    req_v_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if (resp_v_o !== 1'b1 || req_ready_o !== 1'b0 || resp_data_o !== 64'h1_0000_0005) begin
        $display("FAIL hold_cycle_%0d got v=%b rdy=%b data=%h want 1 0 0000000100000005",
                 i, resp_v_o, req_ready_o, resp_data_o);
      end else n_pass++;
      @(negedge clk_i);
    end
    resp_yumi_i = 1'b1;
    @(negedge clk_i);
    resp_yumi_i = 1'b0;
    n = 0;
    n_total++;
    if (resp_v_o !== 1'b0 || req_ready_o !== 1'b1) begin
      $display("FAIL after_yumi got v=%b rdy=%b want 0 1", resp_v_o, req_ready_o);
    end else n_pass++;
  endtask

  task automatic test_reset_mid_txn();
    logic [63:0] d;
    logic e, w;
    @(negedge clk_i);
    req_v_i    = 1'b1;
    req_wr_i   = 1'b0;
    req_addr_i = 40'h00_0030_0000;
    req_size_i = 2'd3;
    @(negedge clk_i);
    req_v_i   = 1'b0;
    reset_n_i = 1'b0;
    #1;
    n_total++;
    if (resp_v_o !== 1'b0 || req_ready_o !== 1'b0 || software_irq_o !== 1'b0) begin
      $display("FAIL mid_reset_abort got v=%b rdy=%b sw=%b want 0 0 0",
               resp_v_o, req_ready_o, software_irq_o);
    end else n_pass++;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    n_total++;
    if (resp_v_o !== 1'b0 || req_ready_o !== 1'b1) begin
      $display("FAIL post_reset_idle got v=%b rdy=%b want 0 1", resp_v_o, req_ready_o);
    end else n_pass++;
    txn(1'b0, 40'h00_0030_B000, 2'd3, 64'd0, 1'b0, d, e, w);
    n_total++;
    if (d !== 64'd0 || external_irq_o !== 1'b0) begin
      $display("FAIL post_reset_plic got data=%h ext=%b want 0 0", d, external_irq_o);
    end else n_pass++;
  endtask

  initial begin
    reset_n_i   = 1'b0;
    rtc_tick_i  = 1'b0;
    req_v_i     = 1'b0;
    req_wr_i    = 1'b0;
    req_addr_i  = '0;
    req_size_i  = '0;
    req_data_i  = '0;
    resp_yumi_i = 1'b0;
    test_reset();
    test_mipi_plic();
    test_timer();
    test_mtime_subword();
    test_mtime_tick_collision();
    test_errors();
    test_backpressure();
    test_reset_mid_txn();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d/%0d checks", n_pass, n_total);
    $fatal(1);
  end

endmodule
